// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Issue/retire wrapper around a combinational signed ALU. Commands (opcode and
// two signed 32-bit operands) are buffered in a small FIFO. They are issued to
// the ALU from a registered issue stage. The ALU answer is captured into a
// result register with its own handshake. Sticky flags and a count of retired
// legal operations are kept for the surrounding datapath.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. A valid source holds its payload stable until that edge. Ready never
// depends combinationally on the valid of the same channel.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          command handshake
//   in_sel, in_a, in_b         opcode (0..11 legal) and signed operands
//   alu_a, alu_b, alu_sel      registered operands/opcode driven to the ALU
//   alu_out, alu_out_m         ALU 32-bit result and 64-bit multiply result
//   alu_cf/zf/of/nf            ALU flags
//   res_valid/res_ready        result handshake
//   res_data, res_flags        64-bit result and {cf,zf,of,nf}
//   res_illegal                result came from opcode 12..15
//   sticky_flags, sticky_clr   OR of retired flags, synchronous clear
//   op_count                   legal results retired (wraps)
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_sel,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_sel,
  input  logic [31:0]      alu_out,
  input  logic [63:0]      alu_out_m,
  input  logic             alu_cf,
  input  logic             alu_zf,
  input  logic             alu_of,
  input  logic             alu_nf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic [3:0]       res_flags,
  output logic             res_illegal,
  output logic [3:0]       sticky_flags,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [3:0] SEL_MUL = 4'b0110;
  localparam logic [3:0] SEL_FIRST_ILLEGAL = 4'd12;

  // ---------------- command FIFO ----------------
  logic [31:0]      fifo_a_q   [FIFO_DEPTH];
  logic [31:0]      fifo_b_q   [FIFO_DEPTH];
  logic [3:0]       fifo_sel_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_full, fifo_empty;

  // ---------------- issue stage ----------------
  logic        iss_v_q, iss_v_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_sel_q, alu_sel_d;

  // ---------------- result stage ----------------
  logic        res_valid_q, res_valid_d;
  logic [63:0] res_data_q, res_data_d;
  logic [3:0]  res_flags_q, res_flags_d;
  logic        res_illegal_q, res_illegal_d;

  logic [3:0]       sticky_q, sticky_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic push, pop, adv_r, retire;
  logic cap_illegal;

  assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Ready comes only from registered occupancy; gating with rst_n keeps the
  // input closed for the whole time reset is asserted.
  assign in_ready = rst_n && !fifo_full;
  assign push     = in_valid && in_ready;

  assign retire = res_valid_q && res_ready;
  assign adv_r  = iss_v_q && (!res_valid_q || res_ready);
  // The issue register refills whenever it is empty or its content moves on.
  assign pop    = !fifo_empty && (!iss_v_q || adv_r);

  assign cap_illegal = (alu_sel_q >= SEL_FIRST_ILLEGAL);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    iss_v_d   = iss_v_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_sel_d = alu_sel_q;
    if (pop) begin
      iss_v_d   = 1'b1;
      alu_a_d   = fifo_a_q[rd_ptr_q];
      alu_b_d   = fifo_b_q[rd_ptr_q];
      alu_sel_d = fifo_sel_q[rd_ptr_q];
    end else if (adv_r) begin
      // Operands stay on alu_* after the stage empties.
      iss_v_d = 1'b0;
    end

    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_flags_d   = res_flags_q;
    res_illegal_d = res_illegal_q;
    if (adv_r) begin
      res_valid_d = 1'b1;
      if (cap_illegal) begin
        res_data_d    = 64'd0;
        res_flags_d   = 4'd0;
        res_illegal_d = 1'b1;
      end else begin
        res_data_d    = (alu_sel_q == SEL_MUL) ? alu_out_m
                                               : {{32{alu_out[31]}}, alu_out};
        res_flags_d   = {alu_cf, alu_zf, alu_of, alu_nf};
        res_illegal_d = 1'b0;
      end
    end else if (retire) begin
      res_valid_d = 1'b0;
    end

    // Clear first, then fold in the flags of a result retiring on this edge.
    sticky_d = (sticky_clr ? 4'd0 : sticky_q) | (retire ? res_flags_q : 4'd0);

    op_count_d = op_count_q;
    if (retire && !res_illegal_q) op_count_d = op_count_q + CNT_W'(1);
  end

  // FIFO storage needs no reset: nothing is pushed while rst_n is low and the
  // pointers/count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q]   <= in_a;
      fifo_b_q[wr_ptr_q]   <= in_b;
      fifo_sel_q[wr_ptr_q] <= in_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      iss_v_q       <= 1'b0;
      alu_a_q       <= 32'd0;
      alu_b_q       <= 32'd0;
      alu_sel_q     <= 4'd0;
      res_valid_q   <= 1'b0;
      res_data_q    <= 64'd0;
      res_flags_q   <= 4'd0;
      res_illegal_q <= 1'b0;
      sticky_q      <= 4'd0;
      op_count_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      iss_v_q       <= iss_v_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_sel_q     <= alu_sel_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_flags_q   <= res_flags_d;
      res_illegal_q <= res_illegal_d;
      sticky_q      <= sticky_d;
      op_count_q    <= op_count_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_sel      = alu_sel_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_flags    = res_flags_q;
  assign res_illegal  = res_illegal_q;
  assign sticky_flags = sticky_q;
  assign op_count     = op_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
`timescale 1ns/1ps
module tb_alu_issue_stage;

  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = 16;
  localparam longint MAX32  = 64'sd2147483647;
  localparam longint MIN32  = -MAX32 - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sel;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [3:0]       alu_sel;
  logic [31:0]      alu_out;
  logic [63:0]      alu_out_m;
  logic             alu_cf, alu_zf, alu_of, alu_nf;
  logic             res_valid;
  logic             res_ready;
  logic [63:0]      res_data;
  logic [3:0]       res_flags;
  logic             res_illegal;
  logic [3:0]       sticky_flags;
  logic             sticky_clr;
  logic [CNT_W-1:0] op_count;

  alu_issue_stage #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sel       (in_sel),
    .in_a         (in_a),
    .in_b         (in_b),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .alu_out_m    (alu_out_m),
    .alu_cf       (alu_cf),
    .alu_zf       (alu_zf),
    .alu_of       (alu_of),
    .alu_nf       (alu_nf),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_flags    (res_flags),
    .res_illegal  (res_illegal),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .op_count     (op_count)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stand-in combinational ALU ----------------
  // 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB, 6 MUL, 7 SLL, 8 SRL, 9 SRA,
  // 10 SLT, 11 PASS_A. Illegal codes produce garbage the DUT must discard.
  logic [32:0] st_sum, st_dif;
  logic [63:0] st_prod;
  logic [31:0] st_res;
  always_comb begin
    st_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    st_dif  = {1'b0, alu_a} - {1'b0, alu_b};
    st_prod = $signed({{32{alu_a[31]}}, alu_a}) * $signed({{32{alu_b[31]}}, alu_b});
    st_res  = 32'd0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (alu_sel)
      4'd0:  st_res = alu_a & alu_b;
      4'd1:  st_res = alu_a | alu_b;
      4'd2:  st_res = alu_a ^ alu_b;
      4'd3:  st_res = ~(alu_a | alu_b);
      4'd4: begin
        st_res = st_sum[31:0];
        alu_cf = st_sum[32];
        alu_of = (alu_a[31] == alu_b[31]) && (st_sum[31] != alu_a[31]);
      end
      4'd5: begin
        st_res = st_dif[31:0];
        alu_cf = st_dif[32];
        alu_of = (alu_a[31] != alu_b[31]) && (st_dif[31] != alu_a[31]);
      end
      4'd6:  st_res = st_prod[31:0];
      4'd7:  st_res = alu_a << alu_b[4:0];
      4'd8:  st_res = alu_a >> alu_b[4:0];
      4'd9:  st_res = $signed(alu_a) >>> alu_b[4:0];
      4'd10: st_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      4'd11: st_res = alu_a;
      default: begin
        st_res = 32'hDEAD_BEEF;
        alu_cf = 1'b1;
        alu_of = 1'b1;
      end
    endcase
    alu_out   = st_res;
    alu_out_m = st_prod;
    alu_zf    = (alu_sel == 4'd6) ? (st_prod == 64'd0) : (st_res == 32'd0);
    alu_nf    = (alu_sel == 4'd6) ? st_prod[63] : st_res[31];
    if (alu_sel >= 4'd12) begin
      alu_zf = 1'b1;
      alu_nf = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // Packed expectation: {data[63:0], cf, zf, of, nf, illegal}.
  function automatic logic [68:0] ref_model(input logic [3:0] s,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, r;
    logic [31:0] r32;
    logic [63:0] d;
    logic cf, of;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    cf = 1'b0;
    of = 1'b0;
    r32 = 32'd0;
    if (s >= 4'd12) return {64'd0, 4'd0, 1'b1};
    if (s == 4'd6) begin
      r = sa * sb;
      d = r;
      return {d, 1'b0, (r == 0), 1'b0, (r < 0), 1'b0};
    end
    case (s)
      4'd0:  r32 = a & b;
      4'd1:  r32 = a | b;
      4'd2:  r32 = a ^ b;
      4'd3:  r32 = ~(a | b);
      4'd4: begin
        r = sa + sb;
        r32 = 32'(r);
        of = (r > MAX32) || (r < MIN32);
        cf = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
      end
      4'd5: begin
        r = sa - sb;
        r32 = 32'(r);
        of = (r > MAX32) || (r < MIN32);
        cf = (a < b);
      end
      4'd7:  r32 = a << b[4:0];
      4'd8:  r32 = a >> b[4:0];
      4'd9: begin
        r = sa >>> b[4:0];
        r32 = 32'(r);
      end
      4'd10: r32 = (sa < sb) ? 32'd1 : 32'd0;
      default: r32 = a;
    endcase
    d = longint'($signed(r32));
    return {d, cf, (r32 == 32'd0), of, r32[31], 1'b0};
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- scoreboard ----------------
  logic [68:0]      exp_q[$];
  logic [68:0]      e_cur;
  logic [3:0]       ret_flags;
  logic [CNT_W-1:0] m_count;
  logic [3:0]       m_sticky;

  initial begin
    m_count  = '0;
    m_sticky = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        m_count  = '0;
        m_sticky = 4'd0;
      end else begin
        ret_flags = 4'd0;
        if (res_valid && res_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            e_cur = exp_q.pop_front();
            check("res_data", res_data, e_cur[68:5]);
            check("res_flags", res_flags, e_cur[4:1]);
            check("res_illegal", res_illegal, e_cur[0]);
            check("op_count", op_count, m_count);
            check("sticky", sticky_flags, m_sticky);
            ret_flags = e_cur[4:1];
            if (!e_cur[0]) m_count = m_count + 1'b1;
          end
        end
        if (sticky_clr) m_sticky = 4'd0;
        m_sticky = m_sticky | ret_flags;
        if (in_valid && in_ready) exp_q.push_back(ref_model(in_sel, in_a, in_b));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    int n;
    in_valid = 1'b1;
    in_sel   = s;
    in_a     = a;
    in_b     = b;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) break;
      @(posedge clk); #1;
    end
    if (n == 200) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, res_valid, 64'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    while ((exp_q.size() != 0 || res_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", (exp_q.size() == 0 && !res_valid), 64'd1);
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", in_ready, 64'd0);
    check("rst_res_valid", res_valid, 64'd0);
    check("rst_res_illegal", res_illegal, 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_flags", res_flags, 64'd0);
    check("rst_alu_a", alu_a, 64'd0);
    check("rst_alu_b", alu_b, 64'd0);
    check("rst_alu_sel", alu_sel, 64'd0);
    check("rst_sticky", sticky_flags, 64'd0);
    check("rst_op_count", op_count, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [3:0]  bp_sel [6];
  logic [31:0] bp_a   [6];
  logic [31:0] bp_b   [6];
  int idx, sent, k, need;
  logic acc;
  logic [CNT_W-1:0] cnt_before;
  logic [3:0]       sticky_before;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 4'd0;
    in_a       = 32'd0;
    in_b       = 32'd0;
    res_ready  = 1'b0;
    sticky_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-stream: three commands parked with res_ready low.
    res_ready = 1'b0;
    send_cmd(4'd4, 32'h0000_1234, 32'h0000_0001);
    send_cmd(4'd2, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
    send_cmd(4'd6, 32'h0000_0003, 32'h0000_0005);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 64'd1);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_stale_result", res_valid, 64'd0);
    end

    // Add with latency check.
    send_cmd(4'd4, 32'd5, 32'hFFFF_FFF9);
    @(posedge clk); #1;
    check("lat_alu_sel", alu_sel, 64'd4);
    check("lat_alu_a", alu_a, 64'd5);
    check("lat_alu_b", alu_b, 64'hFFFF_FFF9);
    check("lat_res_early", res_valid, 64'd0);
    @(posedge clk); #1;
    check("lat_res_valid", res_valid, 64'd1);
    check("add_data", res_data, 64'hFFFF_FFFF_FFFF_FFFE);
    check("add_nf", res_flags[0], 64'd1);
    check("add_zf", res_flags[2], 64'd0);
    check("add_of", res_flags[1], 64'd0);
    drain(50);
    check("add_op_count", op_count, 64'd1);

    // Multiply.
    send_cmd(4'd6, 32'hFFFF_0000, 32'h0001_0000);
    wait_res("mul_res_valid");
    check("mul_data", res_data, 64'hFFFF_FFFF_0000_0000);
    check("mul_nf", res_flags[0], 64'd1);
    check("mul_zf", res_flags[2], 64'd0);
    drain(50);

    // Backpressure: six offered, four fit.
    for (int i = 0; i < 6; i++) begin
      bp_sel[i] = 4'($urandom_range(0, 11));
      bp_a[i]   = rand_opnd();
      bp_b[i]   = rand_opnd();
    end
    res_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_sel   = bp_sel[idx];
      in_a     = bp_a[idx];
      in_b     = bp_b[idx];
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    check("bp_accepted", idx, 64'd4);
    check("bp_in_ready", in_ready, 64'd0);
    res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (idx < 6) begin
        in_valid = 1'b1;
        in_sel   = bp_sel[idx];
        in_a     = bp_a[idx];
        in_b     = bp_b[idx];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_no_gap", res_valid, 64'd1);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_all_accepted", idx, 64'd6);
    drain(50);

    // Illegal opcode.
    cnt_before    = m_count;
    sticky_before = m_sticky;
    send_cmd(4'd12, $urandom(), $urandom());
    wait_res("ill_res_valid");
    check("ill_flag", res_illegal, 64'd1);
    check("ill_data", res_data, 64'd0);
    check("ill_flags", res_flags, 64'd0);
    drain(50);
    check("ill_op_count", op_count, cnt_before);
    check("ill_sticky", sticky_flags, sticky_before);

    // Randomized traffic with random backpressure and sticky clears.
    sent = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 3000 && sent < 300; c++) begin
      res_ready  = ($urandom_range(0, 3) != 0);
      sticky_clr = ($urandom_range(0, 19) == 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_sel   = 4'($urandom_range(0, 15));
        in_a     = rand_opnd();
        in_b     = rand_opnd();
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        in_valid = 1'b0;
        sent++;
      end
    end
    sticky_clr = 1'b0;
    check("rand_sent", sent, 64'd300);
    drain(200);

    // Sticky: clear, overflow, then clear coinciding with a retire.
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    check("sticky_cleared", sticky_flags, 64'd0);
    send_cmd(4'd4, 32'h7FFF_FFFF, 32'h0000_0001);
    drain(50);
    check("sticky_of", sticky_flags[1], 64'd1);
    check("sticky_add", sticky_flags, 64'b0011);
    res_ready = 1'b0;
    send_cmd(4'd0, 32'd0, 32'd0);
    wait_res("and_res_valid");
    sticky_clr = 1'b1;
    res_ready  = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    check("sticky_clr_retire", sticky_flags, 64'b0100);
    drain(50);

    // op_count wrap: fill up to all-ones, then one more.
    need = 65535 - int'(m_count);
    k = 0;
    res_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 4'($urandom_range(0, 11));
    in_a      = $urandom();
    in_b      = $urandom();
    for (int c = 0; c < need + 200 && k < need; c++) begin
      @(negedge clk);
      if (in_ready) k++;
      @(posedge clk); #1;
      in_sel = 4'($urandom_range(0, 11));
      in_a   = $urandom();
      in_b   = $urandom();
    end
    in_valid = 1'b0;
    check("wrap_fill", k, need);
    drain(100);
    check("op_count_all_ones", op_count, 64'hFFFF);
    send_cmd(4'd1, 32'h0000_00F0, 32'h0000_000F);
    drain(50);
    check("op_count_wrap", op_count, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Issue and retire stage wrapped around the combinational signed ALU controller. It accepts ALU commands (opcode plus two signed 32-bit operands) over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU from a registered issue stage and captures the ALU result and flags into an output register with its own valid/ready handshake. It also keeps sticky flags and a count of completed operations for the surrounding datapath.

## Interface
- FIFO_DEPTH, 2: command FIFO entries; power of two, at least 2.
- CNT_W, 16: width of op_count.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid && in_ready at a rising edge.
- in_sel  in  4  ALU opcode; codes 0..11 are legal.
- in_a, in_b  in  32  signed operands.
- alu_a, alu_b  out  32  registered operands to the ALU.
- alu_sel  out  4  registered opcode to the ALU.
- alu_out  in  32  ALU 32-bit result.
- alu_out_m  in  64  ALU 64-bit multiply result.
- alu_cf, alu_zf, alu_of, alu_nf  in  1 each  ALU flags.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed when res_valid && res_ready at a rising edge.
- res_data  out  64  result value.
- res_flags  out  4  {cf,zf,of,nf}, bit 3 down to bit 0.
- res_illegal  out  1  result came from an illegal opcode (12..15).
- sticky_flags  out  4  OR of res_flags over all retired results, {cf,zf,of,nf}.
- sticky_clr  in  1  synchronous clear of sticky_flags.
- op_count  out  CNT_W  number of legal results retired; wraps.

## Operation
- Three stages, each with its own valid bit; there is no other FSM.
  - Command FIFO.
  - Issue register: iss_v, alu_a, alu_b, alu_sel.
  - Result register: res_valid, res_data, res_flags, res_illegal.
- FIFO push on the input handshake. in_ready = !fifo_full, taken from registered occupancy, with no combinational path from res_ready. in_ready is 0 while rst_n is low.
- Result register advance: adv_r = iss_v && (!res_valid || res_ready).
- Issue register load: it loads the FIFO head when the FIFO is non-empty and (!iss_v || adv_r).
  - This pops the FIFO.
  - Push and pop in the same cycle are legal when the FIFO is not full.
- alu_* hold their value while iss_v=1 and the stage is stalled. They keep their last value after iss_v drops.
- Result capture on adv_r, combinational from the ALU outputs:
  - If alu_sel = 4'b0110: res_data = alu_out_m.
  - Otherwise: res_data = alu_out sign-extended to 64 bits.
  - res_flags = {alu_cf, alu_zf, alu_of, alu_nf}; res_illegal = 0.
- Illegal opcode (alu_sel ≥ 12): captured with res_data = 0, res_flags = 0, res_illegal = 1.
- Retire: this is the res_valid && res_ready handshake.
  - Legal result: op_count increments by 1 and wraps from all-ones to 0.
  - Illegal result: op_count is unchanged.
  - sticky_flags |= res_flags.
- sticky_clr: sticky_flags becomes 0.
  - If a retire happens in the same cycle, sticky_flags becomes res_flags of that retiring result. The clear applies first, then the OR.
- res_valid drops after a retire unless a new result is captured on the same edge.
- Commands complete strictly in order; none is lost or duplicated.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - FIFO is emptied.
  - iss_v, res_valid, res_illegal = 0.
  - alu_a, alu_b, alu_sel, res_data, res_flags, sticky_flags, op_count = 0.
  - in_ready = 0 while rst_n is low and 1 on the first cycle after release.
- Reset mid-operation discards every queued, issued and captured command. Nothing pending is retired.
- Latency: a command accepted at edge N is on alu_* after edge N+1. res_valid is high after edge N+2.
- Throughput: one command per cycle when res_ready is held at 1.
- Full backpressure (res_ready = 0): the block holds FIFO_DEPTH + 2 commands before in_ready falls.
- While res_valid=1 and res_ready=0, all res_* outputs are stable.

## Test plan
- Reset: queue 3 commands with res_ready=0, then pulse rst_n low mid-stream → all outputs reach their reset values asynchronously. After release, in_ready=1 and no stale result appears.
- Add: a=5, b=-7, sel=4'b0100, res_ready=1 → res_valid 2 edges after acceptance, res_data=64'hFFFF_FFFF_FFFF_FFFE, nf=1, zf=0, of=0, op_count=1.
- Multiply: a=-65536, b=65536, sel=4'b0110 → res_data=64'hFFFF_FFFF_0000_0000, nf=1, zf=0.
- Backpressure: res_ready=0, offer 6 back-to-back commands → exactly 4 are accepted and in_ready=0. Then set res_ready=1 → 6 results retire in order with no gaps after the pipeline refills.
- Illegal op: sel=4'b1100 → res_illegal=1, res_data=0, res_flags=0; op_count and sticky_flags are unchanged.
- Sticky and wrap:
  - 32'h7FFF_FFFF + 1 with add → sticky of=1.
  - Next, an AND of 0 with 0 retires while sticky_clr=1 → sticky_flags=4'b0100.
  - Preload op_count to all-ones by issuing 65535 legal ops, then retire one more → op_count=0.
